tagged_update_ctrl: RTL and testbench

Commit-side update controller for the TAGE tagged predictor banks. It takes one resolved-branch update request per cycle and picks the provider and alternate tables. It then drives every bank's write port with counter, useful-bit or reallocation commands. It also runs a power-on table-clear sweep and a throttled useful-bit aging policy driven by allocation failures. It sits between the branch-resolution/commit path and the `TABLE_NUM` tagged predictor instances.

---
 rtl/tagged_update_ctrl_pkg.sv | 37 +++
 rtl/tagged_update_ctrl_lfsr.sv | 26 ++
 rtl/tagged_update_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_tagged_update_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tagged_update_ctrl_pkg.sv
// Shared BPU definitions for the tagged-bank update controller:
// geometry, LFSR constants, controller states and the per-bank command bundle.
package tagged_update_ctrl_pkg;

   localparam int unsigned TABLE_NUM        = 4;
   localparam int unsigned PHT_DEPTH        = 2048;
   localparam int unsigned IDX_W            = $clog2(PHT_DEPTH);
   localparam int unsigned PHT_TAG_WIDTH    = 11;
   localparam int unsigned PHT_CTR_WIDTH    = 2;
   localparam int unsigned PHT_USEFUL_WIDTH = 3;
   localparam int unsigned TICK_WIDTH       = 3;
   localparam int unsigned BANK_W           = $clog2(TABLE_NUM);

   // Fibonacci taps 16,14,13,11 expressed as a bit mask over [15:0]
   localparam int unsigned             LFSR_WIDTH = 16;
   localparam logic [LFSR_WIDTH-1:0]   LFSR_TAPS  = 16'hB400;
   localparam logic [LFSR_WIDTH-1:0]   LFSR_SEED  = 16'hACE1;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } ctrl_state_t;

   typedef struct packed {
      logic                        valid;
      logic                        update_ctr;
      logic                        inc_ctr;
      logic                        update_useful;
      logic                        inc_useful;
      logic                        realloc_entry;
      logic [PHT_CTR_WIDTH-1:0]    ctr_bits;
      logic [PHT_USEFUL_WIDTH-1:0] useful_bits;
      logic [PHT_TAG_WIDTH-1:0]    tag;
      logic [IDX_W-1:0]            index;
   } upd_cmd_t;

endpackage

// File: rtl/tagged_update_ctrl_lfsr.sv
// Free-running Fibonacci LFSR; exposes the newest bit as a cheap random choice.
module tagged_update_ctrl_lfsr #(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   output logic lsb
);

   logic [WIDTH-1:0] value;
   logic             fb;

   assign fb  = ^(value & TAPS);
   assign lsb = value[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= SEED;
      end else begin
         value <= {value[WIDTH-2:0], fb};
      end
   end

endmodule

// File: rtl/tagged_update_ctrl.sv
// TAGE tagged-bank update controller: power-on clear sweep, provider/alt
// selection, counter/useful updates, allocation and useful-bit aging.
module tagged_update_ctrl
   import tagged_update_ctrl_pkg::*;
(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  req_valid_i,
   output logic                                  req_ready_o,
   input  logic                                  actual_taken_i,
   input  logic                                  base_taken_i,
   input  logic [TABLE_NUM-1:0]                  tag_hit_i,
   input  logic [TABLE_NUM*PHT_CTR_WIDTH-1:0]    ctr_bits_i,
   input  logic [TABLE_NUM*PHT_USEFUL_WIDTH-1:0] useful_bits_i,
   input  logic [TABLE_NUM*PHT_TAG_WIDTH-1:0]    query_tag_i,
   input  logic [TABLE_NUM*PHT_TAG_WIDTH-1:0]    origin_tag_i,
   input  logic [TABLE_NUM*IDX_W-1:0]            hit_index_i,
   output logic [TABLE_NUM-1:0]                  update_valid_o,
   output logic [TABLE_NUM-1:0]                  update_ctr_o,
   output logic [TABLE_NUM-1:0]                  inc_ctr_o,
   output logic [TABLE_NUM-1:0]                  update_useful_o,
   output logic [TABLE_NUM-1:0]                  inc_useful_o,
   output logic [TABLE_NUM-1:0]                  realloc_entry_o,
   output logic [TABLE_NUM*PHT_CTR_WIDTH-1:0]    update_ctr_bits_o,
   output logic [TABLE_NUM*PHT_USEFUL_WIDTH-1:0] update_useful_bits_o,
   output logic [TABLE_NUM*PHT_TAG_WIDTH-1:0]    update_tag_o,
   output logic [TABLE_NUM*IDX_W-1:0]            update_index_o,
   output logic                                  init_done_o
);

   ctrl_state_t                 state, state_next;
   logic [IDX_W-1:0]            sweep, sweep_next;
   logic [TICK_WIDTH-1:0]       tick, tick_next;
   logic                        lfsr_bit;
   logic                        accept;
   upd_cmd_t                    cmd_c [TABLE_NUM];
   upd_cmd_t                    cmd_q [TABLE_NUM];

   logic [PHT_CTR_WIDTH-1:0]    ctr    [TABLE_NUM];
   logic [PHT_USEFUL_WIDTH-1:0] useful [TABLE_NUM];
   logic [PHT_TAG_WIDTH-1:0]    qtag   [TABLE_NUM];
   logic [PHT_TAG_WIDTH-1:0]    otag   [TABLE_NUM];
   logic [IDX_W-1:0]            idx    [TABLE_NUM];

   logic                        has_prov, has_alt, prov_pred, alt_pred;
   logic                        mispred, alloc, found_lo, found_hi;
   logic [BANK_W-1:0]           prov, alt, cand_lo, cand_hi, chosen;

   tagged_update_ctrl_lfsr #(
      .WIDTH (LFSR_WIDTH),
      .TAPS  (LFSR_TAPS),
      .SEED  (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .lsb (lfsr_bit)
   );

   assign accept = req_valid_i && req_ready_o;

   always_comb begin
      for (int i = 0; i < TABLE_NUM; i++) begin
         ctr[i]    = ctr_bits_i[i*PHT_CTR_WIDTH +: PHT_CTR_WIDTH];
         useful[i] = useful_bits_i[i*PHT_USEFUL_WIDTH +: PHT_USEFUL_WIDTH];
         qtag[i]   = query_tag_i[i*PHT_TAG_WIDTH +: PHT_TAG_WIDTH];
         otag[i]   = origin_tag_i[i*PHT_TAG_WIDTH +: PHT_TAG_WIDTH];
         idx[i]    = hit_index_i[i*IDX_W +: IDX_W];
      end
   end

   // Provider, alternate and allocation-candidate priority selection
   always_comb begin
      has_prov = 1'b0;
      prov     = '0;
      has_alt  = 1'b0;
      alt      = '0;
      found_lo = 1'b0;
      found_hi = 1'b0;
      cand_lo  = '0;
      cand_hi  = '0;
      for (int i = 0; i < TABLE_NUM; i++) begin
         if (tag_hit_i[i]) begin
            has_prov = 1'b1;
            prov     = BANK_W'(i);
         end
      end
      for (int i = 0; i < TABLE_NUM; i++) begin
         if (tag_hit_i[i] && has_prov && (BANK_W'(i) < prov)) begin
            has_alt = 1'b1;
            alt     = BANK_W'(i);
         end
      end
      prov_pred = ctr[prov][PHT_CTR_WIDTH-1];
      alt_pred  = has_alt ? ctr[alt][PHT_CTR_WIDTH-1] : base_taken_i;
      mispred   = (has_prov ? prov_pred : base_taken_i) != actual_taken_i;
      alloc     = mispred && (!has_prov || (prov != BANK_W'(TABLE_NUM-1)));
      for (int i = 0; i < TABLE_NUM; i++) begin
         if ((useful[i] == '0) && (!has_prov || (BANK_W'(i) > prov))) begin
            if (!found_lo) begin
               found_lo = 1'b1;
               cand_lo  = BANK_W'(i);
            end else if (!found_hi) begin
               found_hi = 1'b1;
               cand_hi  = BANK_W'(i);
            end
         end
      end
      chosen = (found_hi && lfsr_bit) ? cand_hi : cand_lo;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
      end else begin
         state <= state_next;
      end
   end

   // Next state, sweep/tick update and per-bank command generation
   always_comb begin
      state_next = state;
      sweep_next = sweep;
      tick_next  = tick;
      for (int i = 0; i < TABLE_NUM; i++) begin
         cmd_c[i] = '0;
      end
      case (state)
         INIT: begin
            for (int i = 0; i < TABLE_NUM; i++) begin
               cmd_c[i].realloc_entry = 1'b1;
               cmd_c[i].index         = sweep;
            end
            sweep_next = sweep + 1'b1;
            if (sweep == IDX_W'(PHT_DEPTH-1)) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               for (int i = 0; i < TABLE_NUM; i++) begin
                  cmd_c[i].ctr_bits    = ctr[i];
                  cmd_c[i].useful_bits = useful[i];
                  cmd_c[i].tag         = otag[i];
                  cmd_c[i].index       = idx[i];
               end
               if (has_prov) begin
                  cmd_c[prov].update_ctr = 1'b1;
                  cmd_c[prov].inc_ctr    = actual_taken_i;
                  if (prov_pred != alt_pred) begin
                     cmd_c[prov].update_useful = 1'b1;
                     cmd_c[prov].inc_useful    = (prov_pred == actual_taken_i);
                  end
               end
               if (alloc) begin
                  if (found_lo) begin
                     cmd_c[chosen].realloc_entry = 1'b1;
                     cmd_c[chosen].tag           = qtag[chosen];
                  end else if (tick == {TICK_WIDTH{1'b1}}) begin
                     // Repeated allocation failures: age every bank above the provider
                     tick_next = '0;
                     for (int i = 0; i < TABLE_NUM; i++) begin
                        if (!has_prov || (BANK_W'(i) > prov)) begin
                           cmd_c[i].update_useful = 1'b1;
                           cmd_c[i].inc_useful    = 1'b0;
                        end
                     end
                  end else begin
                     tick_next = tick + 1'b1;
                  end
               end
            end
         end
         default: state_next = INIT;
      endcase
      for (int i = 0; i < TABLE_NUM; i++) begin
         cmd_c[i].valid = cmd_c[i].update_ctr | cmd_c[i].update_useful |
                          cmd_c[i].realloc_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sweep       <= '0;
         tick        <= '0;
         req_ready_o <= 1'b0;
         init_done_o <= 1'b0;
         for (int i = 0; i < TABLE_NUM; i++) begin
            cmd_q[i] <= '0;
         end
      end else begin
         sweep       <= sweep_next;
         tick        <= tick_next;
         req_ready_o <= (state == RUN);
         init_done_o <= (state == RUN);
         for (int i = 0; i < TABLE_NUM; i++) begin
            cmd_q[i] <= cmd_c[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < TABLE_NUM; i++) begin
         update_valid_o[i]  = cmd_q[i].valid;
         update_ctr_o[i]    = cmd_q[i].update_ctr;
         inc_ctr_o[i]       = cmd_q[i].inc_ctr;
         update_useful_o[i] = cmd_q[i].update_useful;
         inc_useful_o[i]    = cmd_q[i].inc_useful;
         realloc_entry_o[i] = cmd_q[i].realloc_entry;
         update_ctr_bits_o[i*PHT_CTR_WIDTH +: PHT_CTR_WIDTH]          = cmd_q[i].ctr_bits;
         update_useful_bits_o[i*PHT_USEFUL_WIDTH +: PHT_USEFUL_WIDTH] = cmd_q[i].useful_bits;
         update_tag_o[i*PHT_TAG_WIDTH +: PHT_TAG_WIDTH]               = cmd_q[i].tag;
         update_index_o[i*IDX_W +: IDX_W]                             = cmd_q[i].index;
      end
   end

endmodule

// File: tb/tb_tagged_update_ctrl.sv
// Directed, table-driven bench for tagged_update_ctrl with hand-computed expectations.
module tb_tagged_update_ctrl;
   import tagged_update_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i, req_ready_o, actual_taken_i, base_taken_i;
   logic [3:0]  tag_hit_i;
   logic [7:0]  ctr_bits_i;
   logic [11:0] useful_bits_i;
   logic [43:0] query_tag_i, origin_tag_i, hit_index_i;
   logic [3:0]  update_valid_o, update_ctr_o, inc_ctr_o;
   logic [3:0]  update_useful_o, inc_useful_o, realloc_entry_o;
   logic [7:0]  update_ctr_bits_o;
   logic [11:0] update_useful_bits_o;
   logic [43:0] update_tag_o, update_index_o;
   logic        init_done_o;

   always #5 clk = ~clk;

   tagged_update_ctrl dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid_i          (req_valid_i),
      .req_ready_o          (req_ready_o),
      .actual_taken_i       (actual_taken_i),
      .base_taken_i         (base_taken_i),
      .tag_hit_i            (tag_hit_i),
      .ctr_bits_i           (ctr_bits_i),
      .useful_bits_i        (useful_bits_i),
      .query_tag_i          (query_tag_i),
      .origin_tag_i         (origin_tag_i),
      .hit_index_i          (hit_index_i),
      .update_valid_o       (update_valid_o),
      .update_ctr_o         (update_ctr_o),
      .inc_ctr_o            (inc_ctr_o),
      .update_useful_o      (update_useful_o),
      .inc_useful_o         (inc_useful_o),
      .realloc_entry_o      (realloc_entry_o),
      .update_ctr_bits_o    (update_ctr_bits_o),
      .update_useful_bits_o (update_useful_bits_o),
      .update_tag_o         (update_tag_o),
      .update_index_o       (update_index_o),
      .init_done_o          (init_done_o)
   );

   localparam logic [43:0] QTAG = {11'h7A3, 11'h5B2, 11'h3C1, 11'h1D0};
   localparam logic [43:0] OTAG = {11'h123, 11'h234, 11'h345, 11'h456};
   localparam logic [43:0] HIDX = {11'd1500, 11'd1000, 11'd500, 11'd7};
   localparam logic [11:0] U_ONES = {3'd1, 3'd1, 3'd1, 3'd1};

   // Reference LFSR: x^16+x^14+x^13+x^11, shifting left, seed ACE1
   logic [15:0] m_lfsr;
   always @(posedge clk) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        valid;
      logic [3:0]  hit;
      logic [7:0]  ctr;
      logic [11:0] useful;
      logic        actual;
      logic        base;
      int          want;
      logic [23:0] exp_cmd;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [23:0] cmd_vec();
      logic [23:0] v;
      for (int i = 0; i < 4; i++)
         v[i*6 +: 6] = {update_valid_o[i], update_ctr_o[i], inc_ctr_o[i],
                        update_useful_o[i], inc_useful_o[i], realloc_entry_o[i]};
      return v;
   endfunction

   function automatic logic [191:0] mk(input logic rdy, input logic dn, input logic [23:0] cmd,
                                       input logic [7:0] c, input logic [11:0] u,
                                       input logic [43:0] t, input logic [43:0] ix);
      return {58'd0, rdy, dn, cmd, c, u, t, ix};
   endfunction

   function automatic logic [191:0] out_vec();
      return mk(req_ready_o, init_done_o, cmd_vec(), update_ctr_bits_o,
                update_useful_bits_o, update_tag_o, update_index_o);
   endfunction

   function automatic logic [43:0] exp_tags(input logic [23:0] cmd);
      logic [43:0] t;
      for (int i = 0; i < 4; i++)
         t[i*11 +: 11] = cmd[i*6] ? QTAG[i*11 +: 11] : OTAG[i*11 +: 11];
      return t;
   endfunction

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [3:0] h, input logic [7:0] c,
                        input logic [11:0] u, input logic act, input logic b);
      req_valid_i    = vld;
      tag_hit_i      = h;
      ctr_bits_i     = c;
      useful_bits_i  = u;
      actual_taken_i = act;
      base_taken_i   = b;
   endtask

   task automatic check_sweep(input int n);
      int errs = 0;
      int first = -1;
      logic [191:0] g, e, g0, e0;
      g0 = '0;
      e0 = '0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e = mk(1'b0, 1'b0, {4{6'b100001}}, 8'd0, 12'd0, 44'd0, {4{11'(k)}});
         g = out_vec();
         if (g !== e) begin
            errs++;
            if (first < 0) begin
               first = k;
               g0 = g;
               e0 = e;
            end
         end
      end
      n_checks++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL sweep: %0d bad cycles, first at index %0d got %0h expected %0h",
                  errs, first, g0, e0);
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [191:0] e;
      int guard;
      // {valid, hit, ctr b3..b0, useful b3..b0, actual, base, lfsr want(2=any), cmd b3..b0}
      vecs[0]  = '{1'b1, 4'b0101, 8'b00_10_00_01, U_ONES, 1'b1, 1'b0, 2,
                   {6'b000000, 6'b111110, 6'b000000, 6'b000000}};
      vecs[1]  = '{1'b1, 4'b0010, 8'b00_00_11_00, {3'd0, 3'd0, 3'd1, 3'd1}, 1'b0, 1'b1, 0,
                   {6'b000000, 6'b100001, 6'b110000, 6'b000000}};
      vecs[2]  = '{1'b1, 4'b0010, 8'b00_00_11_00, {3'd0, 3'd0, 3'd1, 3'd1}, 1'b0, 1'b1, 1,
                   {6'b100001, 6'b000000, 6'b110000, 6'b000000}};
      vecs[3]  = '{1'b1, 4'b1001, 8'b01_00_00_10, 12'd0, 1'b1, 1'b0, 2,
                   {6'b111100, 6'b000000, 6'b000000, 6'b000000}};
      vecs[4]  = '{1'b1, 4'b0000, 8'd0, {3'd5, 3'd0, 3'd0, 3'd2}, 1'b0, 1'b1, 1,
                   {6'b000000, 6'b100001, 6'b000000, 6'b000000}};
      vecs[5]  = '{1'b1, 4'b0000, 8'd0, {3'd0, 3'd1, 3'd1, 3'd1}, 1'b0, 1'b1, 1,
                   {6'b100001, 6'b000000, 6'b000000, 6'b000000}};
      vecs[6]  = '{1'b1, 4'b0001, 8'b00_00_00_11, U_ONES, 1'b1, 1'b1, 2,
                   {6'b000000, 6'b000000, 6'b000000, 6'b111000}};
      vecs[7]  = '{1'b1, 4'b0110, 8'b00_10_11_00, U_ONES, 1'b1, 1'b0, 2,
                   {6'b000000, 6'b111000, 6'b000000, 6'b000000}};
      vecs[8]  = '{1'b1, 4'b0001, 8'd0, 12'd0, 1'b1, 1'b1, 0,
                   {6'b000000, 6'b000000, 6'b100001, 6'b111100}};
      vecs[9]  = '{1'b0, 4'b0001, 8'b00_00_00_11, 12'd0, 1'b0, 1'b1, 2, 24'd0};
      vecs[10] = '{1'b1, 4'b0010, 8'd0, {3'd1, 3'd1, 3'd0, 3'd0}, 1'b1, 1'b0, 2,
                   {6'b000000, 6'b000000, 6'b111000, 6'b000000}};

      rst          = 1'b1;
      query_tag_i  = QTAG;
      origin_tag_i = OTAG;
      hit_index_i  = HIDX;
      drive(1'b0, 4'd0, 8'd0, 12'd0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check("reset state", out_vec(), mk(1'b0, 1'b0, 24'd0, 8'd0, 12'd0, 44'd0, 44'd0));
      rst = 1'b0;
      check_sweep(2048);
      @(negedge clk);
      check("init done", out_vec(), mk(1'b1, 1'b1, 24'd0, 8'd0, 12'd0, 44'd0, 44'd0));

      // Allocation failures with no provider: 7 silent, 8th ages all banks, 9th silent again
      for (int n = 0; n < 9; n++) begin
         drive(1'b1, 4'b0000, 8'd0, U_ONES, 1'b0, 1'b1);
         @(negedge clk);
         check($sformatf("tick fail %0d", n + 1), out_vec(),
               mk(1'b1, 1'b1, (n == 7) ? {4{6'b100100}} : 24'd0, 8'd0, U_ONES, OTAG, HIDX));
      end
      req_valid_i = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 11; k++) begin
         guard = 0;
         while (vecs[k].want != 2 && m_lfsr[0] != 1'(vecs[k].want) && guard < 64) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 64) begin
            n_checks++;
            n_fail++;
            $display("FAIL vec%0d lfsr wait: bit never reached %0d", k, vecs[k].want);
         end
         drive(vecs[k].valid, vecs[k].hit, vecs[k].ctr, vecs[k].useful,
               vecs[k].actual, vecs[k].base);
         @(negedge clk);
         if (vecs[k].valid)
            e = mk(1'b1, 1'b1, vecs[k].exp_cmd, vecs[k].ctr, vecs[k].useful,
                   exp_tags(vecs[k].exp_cmd), HIDX);
         else
            e = mk(1'b1, 1'b1, 24'd0, 8'd0, 12'd0, 44'd0, 44'd0);
         check($sformatf("vec%0d", k), out_vec(), e);
         req_valid_i = 1'b0;
      end

      // Ten back-to-back requests, each tagged by its bank-0 index
      @(negedge clk);
      check("b2b idle before", out_vec(), mk(1'b1, 1'b1, 24'd0, 8'd0, 12'd0, 44'd0, 44'd0));
      for (int n = 0; n < 10; n++) begin
         hit_index_i = {HIDX[43:11], 11'(100 + n)};
         drive(1'b1, 4'b0001, 8'b00_00_00_10, U_ONES, 1'b1, 1'b1);
         @(negedge clk);
         check($sformatf("b2b %0d", n), out_vec(),
               mk(1'b1, 1'b1, {18'd0, 6'b111000}, 8'b00_00_00_10, U_ONES, OTAG,
                  {HIDX[43:11], 11'(100 + n)}));
      end
      req_valid_i = 1'b0;
      hit_index_i = HIDX;
      @(negedge clk);
      check("b2b idle after", out_vec(), mk(1'b1, 1'b1, 24'd0, 8'd0, 12'd0, 44'd0, 44'd0));

      // Reset with a request in flight, then reset again mid-sweep
      drive(1'b1, 4'b0101, 8'b00_10_00_01, U_ONES, 1'b1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("reset in run", out_vec(), mk(1'b0, 1'b0, 24'd0, 8'd0, 12'd0, 44'd0, 44'd0));
      rst = 1'b0;
      req_valid_i = 1'b0;
      check_sweep(1001);
      rst = 1'b1;
      @(negedge clk);
      check("reset mid sweep", out_vec(), mk(1'b0, 1'b0, 24'd0, 8'd0, 12'd0, 44'd0, 44'd0));
      rst = 1'b0;
      check_sweep(2048);
      @(negedge clk);
      check("init done again", out_vec(), mk(1'b1, 1'b1, 24'd0, 8'd0, 12'd0, 44'd0, 44'd0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
